// File: rtl/rx_beamformer_if.sv
// rx_beamformer_if: signal bundle between the receive beamformer and its
// sequencer / placement logic.
//   slave  (beamformer side): sample_en, start, rx_in in; busy, sum, sum_valid,
//                             done, hit, peak_sum, peak_tof out.
//   master (controller side): the mirror image.
`timescale 1ns/1ps
interface rx_beamformer_if;
  logic        sample_en;
  logic        start;
  logic [7:0]  rx_in;
  logic        busy;
  logic [3:0]  sum;
  logic        sum_valid;
  logic        done;
  logic        hit;
  logic [3:0]  peak_sum;
  logic [10:0] peak_tof;

  modport master (
    output sample_en, start, rx_in,
    input  busy, sum, sum_valid, done, hit, peak_sum, peak_tof
  );

  modport slave (
    input  sample_en, start, rx_in,
    output busy, sum, sum_valid, done, hit, peak_sum, peak_tof
  );
endinterface

// File: rtl/rx_beamformer.sv
// rx_beamformer: receive-side delay-and-sum beamformer for an 8-element array.
// Each 1 MHz sample tick the eight comparator bits are written into per-element
// delay lines; the bit delayed by the element's focal delay is read out, the
// aligned bits are (optionally) weighted and summed, and the peak sum with its
// tick index is tracked over a listen window opened by start.
//
// Ports:
//   clock    system clock (125 MHz)
//   reset_n  asynchronous active-low reset
//   bus      rx_beamformer_if.slave:
//              sample_en/start/rx_in in; busy, sum, sum_valid, done, hit,
//              peak_sum, peak_tof out (all registered)
//
// Build option: RX_BF_APODIZE_EN -- when defined, elements 2..5 carry weight 2
// (sum range 0..12); otherwise all weights are 1 (sum range 0..8).
`timescale 1ns/1ps

// One element's delay line. The line is a plain write-pointer ring with no
// reset; instead the read is forced to 0 until the window has advanced at
// least DLY ticks. Every address read after that point was written inside the
// current window, which is exactly what clearing the lines at start would give.
module rx_bf_lane #(
  parameter int DEPTH = 512,
  parameter int DLY   = 0,
  parameter int TW    = 11,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          wr_en,
  input  logic [AW-1:0] wptr,
  input  logic [TW-1:0] tick_cnt,
  input  logic          din,
  output logic          aligned
);
  logic [DEPTH-1:0] line_mem;
  logic [AW-1:0]    raddr;
  logic             rd_bit;
  logic             armed;

  assign raddr  = wptr - AW'(DLY);
  assign rd_bit = line_mem[raddr];
  assign armed  = int'(tick_cnt) >= DLY;

  // Zero-delay elements take the live input, not the line.
  assign aligned = (DLY == 0) ? din : (armed & rd_bit);

  always_ff @(posedge clock) begin
    if (wr_en) line_mem[wptr] <= din;
  end
endmodule

module rx_beamformer #(
  parameter int DEPTH  = 512,
  parameter int D0     = 0,
  parameter int D1     = 235,
  parameter int D2     = 395,
  parameter int D3     = 475,
  parameter int WINDOW = 1000,
  parameter int THRESH = 6
) (
  input  logic clock,
  input  logic reset_n,
  rx_beamformer_if.slave bus
);
  localparam int NUM_LANES = 8;
  localparam int AW        = $clog2(DEPTH);
  localparam int SW        = 4;
  localparam int TW        = 11;

`ifdef RX_BF_APODIZE_EN
  localparam logic [NUM_LANES-1:0][SW-1:0] WT =
    {4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2, 4'd1, 4'd1};
`else
  localparam logic [NUM_LANES-1:0][SW-1:0] WT = {NUM_LANES{4'd1}};
`endif

  typedef enum logic [1:0] {S_IDLE, S_LISTEN, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [SW-1:0] sum_q, sum_d;
  logic          sum_valid_q, sum_valid_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          hit_q, hit_d;
  logic [SW-1:0] peak_sum_q, peak_sum_d;
  logic [TW-1:0] peak_tof_q, peak_tof_d;

  logic                 tick;
  logic [NUM_LANES-1:0] aligned;
  logic [SW-1:0]        aligned_sum;

  // start wins over a coincident strobe: that sample is dropped.
  assign tick = bus.sample_en & ~bus.start & (state_q == S_LISTEN);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    localparam int DLY = (g == 0 || g == 7) ? D0 :
                         (g == 1 || g == 6) ? D1 :
                         (g == 2 || g == 5) ? D2 : D3;
    rx_bf_lane #(.DEPTH(DEPTH), .DLY(DLY), .TW(TW)) u_lane (
      .clock    (clock),
      .wr_en    (tick),
      .wptr     (wptr_q),
      .tick_cnt (tick_q),
      .din      (bus.rx_in[g]),
      .aligned  (aligned[g])
    );
  end

  always_comb begin
    aligned_sum = '0;
    for (int k = 0; k < NUM_LANES; k++)
      aligned_sum = aligned_sum + (aligned[k] ? WT[k] : SW'(0));
  end

  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    wptr_d      = wptr_q;
    sum_d       = sum_q;
    sum_valid_d = 1'b0;
    done_d      = 1'b0;
    hit_d       = hit_q;
    peak_sum_d  = peak_sum_q;
    peak_tof_d  = peak_tof_q;

    if (bus.start) begin
      state_d    = S_LISTEN;
      tick_d     = '0;
      wptr_d     = '0;
      peak_sum_d = '0;
      peak_tof_d = '0;
      hit_d      = 1'b0;
    end else begin
      case (state_q)
        S_LISTEN: begin
          if (tick) begin
            sum_d       = aligned_sum;
            sum_valid_d = 1'b1;
            // Strict compare: the earliest tick keeps a tie.
            if (aligned_sum > peak_sum_q) begin
              peak_sum_d = aligned_sum;
              peak_tof_d = tick_q;
            end
            hit_d  = int'(peak_sum_d) >= THRESH;
            wptr_d = wptr_q + 1'b1;
            tick_d = tick_q + 1'b1;
            if (tick_q == TW'(WINDOW - 1)) state_d = S_DONE;
          end
        end
        // done is raised one cycle after the final sum, together with busy
        // dropping; a start landing here restarts and suppresses it.
        S_DONE: begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      tick_q      <= '0;
      wptr_q      <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      hit_q       <= 1'b0;
      peak_sum_q  <= '0;
      peak_tof_q  <= '0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      wptr_q      <= wptr_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      hit_q       <= hit_d;
      peak_sum_q  <= peak_sum_d;
      peak_tof_q  <= peak_tof_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.sum       = sum_q;
  assign bus.sum_valid = sum_valid_q;
  assign bus.done      = done_q;
  assign bus.hit       = hit_q;
  assign bus.peak_sum  = peak_sum_q;
  assign bus.peak_tof  = peak_tof_q;
endmodule
